adc_sample_capture: RTL
=======================

// Module: adc_sample_capture
// PURPOSE
// - Downstream of the ping/convert sequencer. Consumes its convert_o pulse train and ping_o.
// - On each convert rising edge: waits out the ADC conversion, then reads one SAMPLE_W-bit
//   sample over a 3-wire serial link (cs_n/sclk/sdo).
// - Buffers samples in a small FIFO and streams them out on a valid/ready interface.
//   The first sample after each ping rising edge is tagged as start-of-frame.
// PARAMETERS
// - SAMPLE_W    12  bits per ADC sample, MSB first
// - CONV_CYCLES 2   clk cycles from the convert edge to cs_n assertion (ADC conversion time)
// - SCLK_HALF   1   clk cycles per sclk half-period
// - FIFO_DEPTH  4   output FIFO entries; must be a power of two
// - CNT_W       16  width of the per-frame sample counter
// PORTS
// - clk_i            in   1         system clock (108 MHz)
// - rst_ni           in   1         asynchronous, active-low reset
// - convert_i        in   1         convert pulse train, synchronous to clk_i
// - ping_i           in   1         ping window, synchronous to clk_i; rising edge = new frame
// - sdo_i            in   1         ADC serial data
// - cs_n_o           out  1         ADC chip select, active low
// - sclk_o           out  1         ADC serial clock
// - m_data_o         out  SAMPLE_W  sample at the FIFO head
// - m_sof_o          out  1         head sample is the first of its frame
// - m_valid_o        out  1         FIFO not empty
// - m_ready_i        in   1         consumer accepts; pop when m_valid_o && m_ready_i
// - sample_count_o   out  CNT_W     samples pushed since the last ping edge; saturates at all-ones
// - dropped_o        out  1         sticky: a convert edge arrived while busy
// - overflow_o       out  1         sticky: a sample was discarded because the FIFO was full
// BEHAVIOUR
// - Reset values: cs_n_o=1, sclk_o=0, m_valid_o=0, m_sof_o=0, m_data_o=0,
//   sample_count_o=0, dropped_o=0, overflow_o=0. FSM in IDLE, FIFO empty.
// - Edge detect: one register per input. Edge = input high while its register is low.
// - FSM states:
//   - IDLE: on a convert edge go to CONV, timer cleared.
//   - CONV: hold for CONV_CYCLES cycles, then enter READ.
//   - READ: cs_n_o=0. sclk_o starts low and toggles every SCLK_HALF cycles.
//     sdo_i is shifted in on the clk edge that drives sclk_o 1->0.
//     After SAMPLE_W falling edges go to PUSH with sclk_o=0.
//   - PUSH: cs_n_o=1. Write {sof_pend, shift_reg} into the FIFO. Return to IDLE.
// - Latency: convert edge to FIFO write = 1 + CONV_CYCLES + 2*SCLK_HALF*SAMPLE_W + 1.
//   Defaults give 28 cycles. m_valid_o rises the cycle after the write.
// - Convert edge outside IDLE: ignored, dropped_o set. An in-flight read is never aborted.
// - Ping edge:
//   - sets sof_pend and clears sample_count_o, dropped_o and overflow_o.
//   - sof_pend clears on the next PUSH.
//   - Ping edge in the same cycle as PUSH: the pushed sample carries SOF, sof_pend stays
//     set, and the counter restarts at 0.
// - FIFO full at PUSH: sample discarded, overflow_o set, counter not incremented.
//   Full with a pop in the same cycle counts as not full: push and pop both occur.
// - Counter increments on each successful push and saturates, no wrap.
// - Reset asserted mid-READ: outputs go to reset values immediately; partial sample lost.
// CONFIGURATION
// - Macro ADC_TEST_PATTERN_EN.
// - Defined: adds input test_pattern_i. When it is 1, PUSH writes
//   sample_count_o[SAMPLE_W-1:0] instead of the shift register. The serial bus still runs.
// - Undefined: no test_pattern_i port; samples always come from sdo_i.
// STRUCTURE
// - Package adc_capture_pkg: state enum (IDLE, CONV, READ, PUSH) and default constants
//   (SAMPLE_W, CONV_CYCLES, SCLK_HALF).
// - Sub-module sample_fifo: synchronous FIFO, width SAMPLE_W+1, first-word-fall-through,
//   async active-low reset.
// - Top level holds edge detect, FSM, shift register, counters and sticky flags.
// TESTING
// - Single capture: ping edge, one convert edge, sdo drives 0xA5C MSB first.
//   Expect m_data_o=0xA5C, m_sof_o=1, m_valid_o 29 cycles after the edge, sample_count_o=1.
// - Pulse train: 30-cycle convert period, 8 pulses, m_ready_i=1.
//   Expect 8 samples in order, only the first with sof, dropped_o=0.
// - Busy collision: second convert edge 10 cycles after the first.
//   Expect one sample and dropped_o=1. The next ping edge clears dropped_o.
// - Backpressure: m_ready_i=0 for 6 captures.
//   Expect 4 samples retained, overflow_o=1, sample_count_o=4. Then drain with m_ready_i=1.
// - Reset mid-READ: deassert rst_ni at bit 5.
//   Expect cs_n_o=1, sclk_o=0 and m_valid_o=0 asynchronously. The next capture is correct.
// - With ADC_TEST_PATTERN_EN and test_pattern_i=1: 3 captures give data 0,1,2.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and default constants for the ADC sample capture block.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2,
        PUSH = 2'd3
    } state_t;

    localparam int unsigned DEF_SAMPLE_W    = 12;
    localparam int unsigned DEF_CONV_CYCLES = 2;
    localparam int unsigned DEF_SCLK_HALF   = 1;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_CNT_W       = 16;

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO (DEPTH a power of two, >= 2).
// Latency: a write is visible at pop_dat/pop_vld the cycle after it is accepted.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned W     = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push_fire;
    logic          pop_fire;

    assign pop_vld   = (cnt_q != '0);
    assign pop_fire  = pop_vld && pop_rdy;
    assign push_rdy  = (cnt_q != (AW+1)'(DEPTH)) || pop_fire;
    assign push_fire = push_vld && push_rdy;
    // Head is forced to zero when empty so the output never shows stale storage.
    assign pop_dat   = pop_vld ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_capture.sv
// Serial ADC capture: per convert edge, wait conversion, shift in one sample, queue it. Option: ADC_TEST_PATTERN_EN.
// Latency: convert edge to FIFO write 1+CONV_CYCLES+2*SCLK_HALF*SAMPLE_W+1 cycles; m_valid_o one cycle later.
// Backpressure: m_ready_i low fills the FIFO; later samples are discarded and flagged on overflow_o.
module adc_sample_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int unsigned SCLK_HALF   = DEF_SCLK_HALF,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                convert_i,
    input  logic                ping_i,
    input  logic                sdo_i,
    output logic                cs_n_o,
    output logic                sclk_o,
    output logic [SAMPLE_W-1:0] m_data_o,
    output logic                m_sof_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                test_pattern_i,
`endif
    output logic [CNT_W-1:0]    sample_count_o,
    output logic                dropped_o,
    output logic                overflow_o
);

    localparam int unsigned TMR_W  = cnt_bits(CONV_CYCLES);
    localparam int unsigned HALF_W = cnt_bits(SCLK_HALF);
    localparam int unsigned BIT_W  = cnt_bits(SAMPLE_W);

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                shift_en;
    logic                push_vld;

    logic                convert_q;
    logic                ping_q;
    logic                conv_edge;
    logic                ping_edge;
    logic [SAMPLE_W-1:0] shift_q;
    logic                sof_pend_q;
    logic [CNT_W-1:0]    count_q;
    logic                dropped_q;
    logic                overflow_q;

    logic                push_rdy;
    logic [SAMPLE_W-1:0] sample_sel;
    logic [SAMPLE_W:0]   push_dat;
    logic [SAMPLE_W:0]   head_dat;

    assign conv_edge = convert_i && !convert_q;
    assign ping_edge = ping_i && !ping_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        half_d   = half_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        shift_en = 1'b0;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv_edge) begin
                    state_d = CONV;
                    tmr_d   = '0;
                end
            end
            CONV: begin
                if (tmr_q == TMR_W'(CONV_CYCLES - 1)) begin
                    state_d = READ;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            READ: begin
                if (half_q == HALF_W'(SCLK_HALF - 1)) begin
                    half_d = '0;
                    sclk_d = !sclk_q;
                    // Data is taken on the edge that drives sclk low.
                    if (sclk_q) begin
                        shift_en = 1'b1;
                        bit_d    = bit_q + 1'b1;
                        if (bit_q == BIT_W'(SAMPLE_W - 1)) begin
                            state_d = PUSH;
                            cs_n_d  = 1'b1;
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            PUSH: begin
                push_vld = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ADC_TEST_PATTERN_EN
    assign sample_sel = test_pattern_i ? count_q[SAMPLE_W-1:0] : shift_q;
`else
    assign sample_sel = shift_q;
`endif

    // A ping landing on the PUSH cycle still tags this sample as start-of-frame.
    assign push_dat = {sof_pend_q || ping_edge, sample_sel};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            convert_q  <= 1'b0;
            ping_q     <= 1'b0;
            shift_q    <= '0;
            sof_pend_q <= 1'b0;
            count_q    <= '0;
            dropped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            convert_q <= convert_i;
            ping_q    <= ping_i;
            if (shift_en) begin
                shift_q <= {shift_q[SAMPLE_W-2:0], sdo_i};
            end
            if (ping_edge) begin
                sof_pend_q <= 1'b1;
            end else if (push_vld) begin
                sof_pend_q <= 1'b0;
            end
            if (ping_edge) begin
                count_q <= '0;
            end else if (push_vld && push_rdy && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
            if (ping_edge) begin
                dropped_q <= 1'b0;
            end else if (conv_edge && (state_q != IDLE)) begin
                dropped_q <= 1'b1;
            end
            if (ping_edge) begin
                overflow_q <= 1'b0;
            end else if (push_vld && !push_rdy) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .W     (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat (push_dat),
        .pop_vld  (m_valid_o),
        .pop_rdy  (m_ready_i),
        .pop_dat  (head_dat)
    );

    assign m_data_o       = head_dat[SAMPLE_W-1:0];
    assign m_sof_o        = head_dat[SAMPLE_W];
    assign cs_n_o         = cs_n_q;
    assign sclk_o         = sclk_q;
    assign sample_count_o = count_q;
    assign dropped_o      = dropped_q;
    assign overflow_o     = overflow_q;

endmodule
